persp_div_issuer: RTL



---
 rtl/persp_div_pkg.sv | 11 +
 rtl/persp_div_fifo.sv | 54 +++++
 rtl/persp_div_issuer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/persp_div_pkg.sv
// persp_div_pkg: shared state encoding, vector type and collector sizing for persp_div_issuer
package persp_div_pkg;
  localparam int VEC_W = 21;
  localparam int IDX_W = 2;
  typedef enum logic [2:0] {DRAIN, IDLE, ISS_X, ISS_Y, ISS_Z} state_t;
  typedef struct packed {
    logic [VEC_W-1:0] x;
    logic [VEC_W-1:0] y;
    logic [VEC_W-1:0] z;
  } vec3_t;
endpackage

// File: rtl/persp_div_fifo.sv
// persp_div_fifo: first-word-fall-through result FIFO of vec3_t, depth DEPTH
// Ports: clk, rst (sync, active-high); push/din write; pop/dout read head; count = entries held.
// With PERSP_DIVZERO_DETECT_EN a divide-by-zero flag (din_dz/dout_dz) travels with each entry.
module persp_div_fifo
  import persp_div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  vec3_t         din,
  input  logic          pop,
  output vec3_t         dout,
  output logic [CW-1:0] count
`ifdef PERSP_DIVZERO_DETECT_EN
  ,
  input  logic          din_dz,
  output logic          dout_dz
`endif
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  vec3_t mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr == PW'(DEPTH - 1) ? '0 : wr + 1'b1;
      end
      if (do_pop) rd <= rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
`ifdef PERSP_DIVZERO_DETECT_EN
  logic [DEPTH-1:0] dzm;
  assign dout_dz = dzm[rd];
  always_ff @(posedge clk) begin
    if (rst) dzm <= '0;
    else if (push) dzm[wr] <= din_dz;
  end
`endif
  // Issue credit keeps pushes from ever landing on a full FIFO.
  assert property (@(posedge clk) disable iff (rst) push |-> (count != CW'(DEPTH) || do_pop));
endmodule

// File: rtl/persp_div_issuer.sv
// persp_div_issuer: issues x/w, y/w, z/w to the divider per vertex and regroups quotients into vectors
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_x..in_w vertex in; open/dividend/divisor
// divide request; finish/quotient divide result; out_valid/out_ready/out_x..out_z vectors out;
// err_unexpected sticky stray-finish flag. PERSP_DIVZERO_DETECT_EN adds out_divzero and forces
// all-ones quotients for w==0 vertices.
module persp_div_issuer
  import persp_div_pkg::*;
#(
  parameter int W = 21,
  parameter int MAX_INFLIGHT = 4,
  parameter int DIV_LATENCY = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [W-1:0] in_z,
  input  logic [W-1:0] in_w,
  output logic         open,
  output logic [W-1:0] dividend,
  output logic [W-1:0] divisor,
  input  logic         finish,
  input  logic [W-1:0] quotient,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_z,
  output logic         err_unexpected
`ifdef PERSP_DIVZERO_DETECT_EN
  ,
  output logic         out_divzero
`endif
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int DW = $clog2(DIV_LATENCY + 2);
  state_t state;
  logic [DW-1:0] cnt;
  logic [W-1:0] y_reg, z_reg, x_hold, y_hold;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0] inflight, count;
  logic accept, take, push;
  vec3_t head;
  // Credit covers both vectors still in the divider and vectors parked in the FIFO.
  assign in_ready = state == IDLE && ({1'b0, count} + {1'b0, inflight}) < (CW + 1)'(MAX_INFLIGHT);
  assign accept = in_valid && in_ready;
  assign take = finish && state != DRAIN && inflight != '0;
  assign push = take && idx == IDX_W'(2);
  assign out_valid = count != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DRAIN;
      cnt <= '0;
      open <= 1'b0;
      dividend <= '0;
      divisor <= '0;
      y_reg <= '0;
      z_reg <= '0;
      x_hold <= '0;
      y_hold <= '0;
      idx <= '0;
      inflight <= '0;
      err_unexpected <= 1'b0;
    end else begin
      case (state)
        // Results of divides issued before reset still emerge; swallow them here.
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == DW'(DIV_LATENCY + 1)) state <= IDLE;
        end
        IDLE: if (accept) begin
          state <= ISS_X;
          open <= 1'b1;
          dividend <= in_x;
          divisor <= in_w;
          y_reg <= in_y;
          z_reg <= in_z;
        end
        ISS_X: begin
          state <= ISS_Y;
          dividend <= y_reg;
        end
        ISS_Y: begin
          state <= ISS_Z;
          dividend <= z_reg;
        end
        default: begin
          state <= IDLE;
          open <= 1'b0;
        end
      endcase
      inflight <= inflight + CW'(accept) - CW'(push);
      if (take) begin
        idx <= push ? '0 : idx + 1'b1;
        if (idx == '0) x_hold <= quotient;
        if (idx == IDX_W'(1)) y_hold <= quotient;
      end
      if (finish && state != DRAIN && inflight == '0) err_unexpected <= 1'b1;
    end
  end
`ifdef PERSP_DIVZERO_DETECT_EN
  // Oldest in-flight vector's flag sits in bit 0; new flags land just past the survivors.
  logic [(1<<CW)-1:0] dz_q, dz_n;
  logic dz_head;
  always_comb begin
    dz_n = push ? dz_q >> 1 : dz_q;
    if (accept) dz_n[inflight - CW'(push)] = in_w == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) dz_q <= '0;
    else dz_q <= dz_n;
  end
  persp_div_fifo #(.DEPTH(MAX_INFLIGHT)) fifo (
    .clk(clk), .rst(rst), .push(push), .din('{x_hold, y_hold, quotient}),
    .pop(out_ready), .dout(head), .count(count), .din_dz(dz_q[0]), .dout_dz(dz_head)
  );
  assign out_divzero = out_valid && dz_head;
  assign out_x = dz_head ? '1 : head.x;
  assign out_y = dz_head ? '1 : head.y;
  assign out_z = dz_head ? '1 : head.z;
`else
  persp_div_fifo #(.DEPTH(MAX_INFLIGHT)) fifo (
    .clk(clk), .rst(rst), .push(push), .din('{x_hold, y_hold, quotient}),
    .pop(out_ready), .dout(head), .count(count)
  );
  assign out_x = head.x;
  assign out_y = head.y;
  assign out_z = head.z;
`endif
endmodule
